procfix_stream_io: RTL and testbench

Stream-side I/O responder for the fixed-point soft processor: it answers the processor's per-port input requests (`req_in`) by presenting data on `io_in`, and captures the processor's per-port output strobes (`out_en`) from `io_out`. Port 0 in each direction is a FIFO-buffered valid/ready data stream to and from the surrounding system. Port 1 in each direction is a status/control register. The block sits between the processor top level and external stream logic, one clock domain.

---
 rtl/procfix_stream_io.sv | 203 ++++++++++++++++++++
 tb/tb_procfix_stream_io.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/procfix_stream_io.sv
// Stream-side I/O responder for the fixed-point soft processor.
// Port 0 bridges FIFO-buffered streams; port 1 is a status/control register.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-low
//   req_in   processor input-port read strobes (one-hot or zero)
//   io_in    data returned to processor (combinational)
//   out_en   processor output-port write strobes (one-hot or zero)
//   io_out   data written by processor
//   s_data   upstream stream data
//   s_valid  upstream data valid
//   s_ready  input FIFO can accept
//   m_data   downstream stream data (registered)
//   m_valid  downstream data valid (registered)
//   m_ready  downstream accepts
module procfix_stream_io #(
    parameter int NUBITS = 31,
    parameter int FDEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_in,
    output logic [NUBITS-1:0] io_in,
    input  logic [1:0]        out_en,
    input  logic [NUBITS-1:0] io_out,
    input  logic [NUBITS-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [NUBITS-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int AW = $clog2(FDEPTH);
    localparam int C  = AW + 1;

    // ---------------- state ----------------
    logic [NUBITS-1:0] in_mem [FDEPTH];
    logic [AW-1:0]     in_wr;
    logic [AW-1:0]     in_rd;
    logic [C-1:0]      in_count;

    logic [NUBITS-1:0] out_mem [FDEPTH];
    logic [AW-1:0]     out_wr;
    logic [AW-1:0]     out_rd;
    logic [C-1:0]      out_count;

    logic              udf;
    logic              ovf;

    // ---------------- next state ----------------
    logic [AW-1:0]     in_wr_nxt;
    logic [AW-1:0]     in_rd_nxt;
    logic [C-1:0]      in_count_nxt;
    logic [AW-1:0]     out_wr_nxt;
    logic [AW-1:0]     out_rd_nxt;
    logic [C-1:0]      out_count_nxt;
    logic [NUBITS-1:0] m_data_nxt;
    logic              m_valid_nxt;
    logic              udf_nxt;
    logic              ovf_nxt;

    // ---------------- events ----------------
    logic in_full;
    logic in_empty;
    logic out_full;
    logic flush;
    logic clr;
    logic in_push;
    logic in_pop;
    logic udf_evt;
    logic out_push;
    logic out_pop;
    logic ovf_evt;

    logic [NUBITS-1:0] status;

    assign in_full  = (in_count == C'(FDEPTH));
    assign in_empty = (in_count == '0);
    assign out_full = (out_count == C'(FDEPTH));

    assign flush = out_en[1] & io_out[1];
    assign clr   = out_en[1] & io_out[0];

    // Readiness depends only on fullness, so a same-cycle pop never
    // opens a slot for a push while full.
    assign s_ready = rst & ~in_full;

    assign in_push = s_valid & s_ready;
    assign in_pop  = req_in[0] & ~in_empty;
    assign udf_evt = req_in[0] & in_empty;

    assign out_push = out_en[0] & ~out_full;
    assign ovf_evt  = out_en[0] & out_full;
    assign out_pop  = m_valid & m_ready;

    // ---------------- status word / read mux ----------------
    always_comb begin
        status            = '0;
        status[C-1:0]     = in_count;
        status[2*C-1:C]   = out_count;
        status[2*C]       = udf;
        status[2*C+1]     = ovf;
    end

    always_comb begin
        io_in = '0;
        if (req_in[1]) begin
            io_in = status;
        end else if (!in_empty) begin
            io_in = in_mem[in_rd];
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        in_wr_nxt     = in_wr + AW'(in_push);
        in_rd_nxt     = in_rd + AW'(in_pop);
        in_count_nxt  = in_count + C'(in_push) - C'(in_pop);

        out_wr_nxt    = out_wr + AW'(out_push);
        out_rd_nxt    = out_rd + AW'(out_pop);
        out_count_nxt = out_count + C'(out_push) - C'(out_pop);

        udf_nxt = udf;
        if (clr) begin
            udf_nxt = 1'b0;
        end
        if (udf_evt) begin
            udf_nxt = 1'b1;
        end

        ovf_nxt = ovf;
        if (clr) begin
            ovf_nxt = 1'b0;
        end
        if (ovf_evt) begin
            ovf_nxt = 1'b1;
        end

        if (flush) begin
            in_wr_nxt     = '0;
            in_rd_nxt     = '0;
            in_count_nxt  = '0;
            out_wr_nxt    = '0;
            out_rd_nxt    = '0;
            out_count_nxt = '0;
            udf_nxt       = clr ? 1'b0 : udf;
            ovf_nxt       = clr ? 1'b0 : ovf;
        end

        // m_data mirrors the next head. If that slot is being written
        // this cycle (FIFO otherwise empty), forward io_out directly.
        m_valid_nxt = (out_count_nxt != '0);
        m_data_nxt  = m_data;
        if (m_valid_nxt) begin
            if (out_push && (out_wr == out_rd_nxt)) begin
                m_data_nxt = io_out;
            end else begin
                m_data_nxt = out_mem[out_rd_nxt];
            end
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (rst && in_push && !flush) begin
            in_mem[in_wr] <= s_data;
        end
        if (rst && out_push && !flush) begin
            out_mem[out_wr] <= io_out;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_count  <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
            udf       <= 1'b0;
            ovf       <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
        end else begin
            in_wr     <= in_wr_nxt;
            in_rd     <= in_rd_nxt;
            in_count  <= in_count_nxt;
            out_wr    <= out_wr_nxt;
            out_rd    <= out_rd_nxt;
            out_count <= out_count_nxt;
            udf       <= udf_nxt;
            ovf       <= ovf_nxt;
            m_valid   <= m_valid_nxt;
            m_data    <= m_data_nxt;
        end
    end

endmodule

// File: tb/tb_procfix_stream_io.sv
// Scoreboard bench for procfix_stream_io: expected io_in / m_data words are
// queued by the stimulus and popped by an independent negedge monitor.
module tb_procfix_stream_io;

    localparam int NUBITS = 31;
    localparam int FDEPTH = 8;

    logic              clk;
    logic              rst;
    logic [1:0]        req_in;
    logic [NUBITS-1:0] io_in;
    logic [1:0]        out_en;
    logic [NUBITS-1:0] io_out;
    logic [NUBITS-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [NUBITS-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    int checks;
    int failures;

    logic [NUBITS-1:0] exp_io [$];
    logic [NUBITS-1:0] exp_m  [$];

    procfix_stream_io #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .io_in   (io_in),
        .out_en  (out_en),
        .io_out  (io_out),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NUBITS-1:0] act,
                       input logic [NUBITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input logic [NUBITS-1:0] e);
        exp_io.push_back(e);
        req_in = 2'b01;
        tick();
        req_in = 2'b00;
    endtask

    task automatic rd1(input logic [NUBITS-1:0] e);
        exp_io.push_back(e);
        req_in = 2'b10;
        tick();
        req_in = 2'b00;
    endtask

    task automatic ctrl(input logic [NUBITS-1:0] v);
        out_en = 2'b10;
        io_out = v;
        tick();
        out_en = 2'b00;
        io_out = '0;
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    initial begin
        logic [NUBITS-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && req_in != 2'b00) begin
                if (exp_io.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL io_in_unexpected: got 0x%0h expected none", io_in);
                end else begin
                    e = exp_io.pop_front();
                    chk("io_in", io_in, e);
                end
            end
            // A handshake in a flush cycle is discarded, not delivered.
            if (rst && m_valid && m_ready && !(out_en[1] && io_out[1])) begin
                if (exp_m.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m_data_unexpected: got 0x%0h expected none", m_data);
                end else begin
                    e = exp_m.pop_front();
                    chk("m_data", m_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        req_in   = 2'b00;
        out_en   = 2'b00;
        io_out   = '0;
        s_data   = 31'h55;
        s_valid  = 1'b1;
        m_ready  = 1'b0;

        // ---- reset ----
        repeat (3) tick();
        chk("rst_s_ready", {30'd0, s_ready}, 31'd0);
        chk("rst_m_valid", {30'd0, m_valid}, 31'd0);
        chk("rst_io_in", io_in, 31'd0);
        chk("rst_m_data", m_data, 31'd0);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("post_rst_s_ready", {30'd0, s_ready}, 31'd1);
        rd1(31'd0);

        // ---- input order and backpressure ----
        for (int i = 0; i < 8; i++) begin
            s_data  = 31'h10 + 31'(i);
            s_valid = 1'b1;
            chk("in_ready", {30'd0, s_ready}, 31'd1);
            tick();
        end
        s_data = 31'h18;
        chk("in_full_ready", {30'd0, s_ready}, 31'd0);
        for (int i = 0; i < 8; i++) begin
            acc = s_valid & s_ready;
            rd0(31'h10 + 31'(i));
            if (acc) s_valid = 1'b0;
        end
        chk("in_18_accepted", {30'd0, s_valid}, 31'd0);
        rd1(31'h1);
        rd0(31'h18);
        rd1(31'h0);

        // ---- underflow ----
        rd0(31'd0);
        rd1(31'h100);
        ctrl(31'd1);
        rd1(31'h0);

        // ---- output path ----
        m_ready = 1'b0;
        out_en  = 2'b01;
        io_out  = 31'(-5);
        exp_m.push_back(31'(-5));
        tick();
        chk("out_valid_1", {30'd0, m_valid}, 31'd1);
        chk("out_data_1", m_data, 31'(-5));
        io_out = 31'd7;
        exp_m.push_back(31'd7);
        tick();
        out_en = 2'b00;
        tick();
        chk("out_hold_valid", {30'd0, m_valid}, 31'd1);
        chk("out_hold_data", m_data, 31'(-5));
        m_ready = 1'b1;
        tick();
        chk("out_second", m_data, 31'd7);
        tick();
        chk("out_drained", {30'd0, m_valid}, 31'd0);
        m_ready = 1'b0;

        // ---- overflow ----
        for (int i = 0; i < 9; i++) begin
            out_en = 2'b01;
            io_out = 31'h100 + 31'(i);
            if (i < 8) exp_m.push_back(31'h100 + 31'(i));
            tick();
        end
        out_en = 2'b00;
        io_out = '0;
        rd1(31'h280);
        m_ready = 1'b1;
        repeat (10) tick();
        m_ready = 1'b0;
        chk("ovf_drain_left", 31'(exp_m.size()), 31'd0);
        rd1(31'h200);
        ctrl(31'd1);
        rd1(31'h0);

        // ---- flush collision ----
        for (int i = 0; i < 3; i++) begin
            s_data  = 31'h40 + 31'(i);
            s_valid = 1'b1;
            out_en  = 2'b01;
            io_out  = 31'h60 + 31'(i);
            tick();
        end
        s_valid = 1'b0;
        out_en  = 2'b00;
        rd1(31'h33);
        out_en  = 2'b10;
        io_out  = 31'd2;
        s_data  = 31'h77;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        out_en  = 2'b00;
        io_out  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("flush_m_valid", {30'd0, m_valid}, 31'd0);
        chk("flush_io_in", io_in, 31'd0);
        rd1(31'h0);

        // ---- function after flush ----
        s_data  = 31'h33;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        rd0(31'h33);

        tick();
        chk("io_queue_left", 31'(exp_io.size()), 31'd0);
        chk("m_queue_left", 31'(exp_m.size()), 31'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
